apb_host_master: RTL and testbench

APB master that turns single-word host requests into APB read/write transfers toward the k-means register file. It is the initiating end of the register-file APB interface and replaces the behavioural stub for CPU-side configuration: centroids, RAM address/data, thresholds, GO, and status polling. Each accepted request produces exactly one response. A per-transfer timeout guarantees completion even when the register file refuses transfers while GO is set.

---
 rtl/apb_host_master.sv | 153 +++++++++++++++
 tb/tb_apb_host_master.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_host_master.sv
// apb_host_master: turns single-word host requests into APB read/write
// transfers toward the k-means register file. One response per accepted
// request; a per-transfer wait counter aborts transfers the register file
// never completes (e.g. while GO is set).
//
// Handshake: a request is taken on any rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE. rsp_valid is a
// single-cycle pulse with no backpressure; rsp_rdata/rsp_err are meaningful
// only while rsp_valid is high.
module apb_host_master #(
  parameter int addrWidth     = 9,
  parameter int dataWidth     = 91,
  parameter int timeout_width = 8,
  // Maximum ACCESS cycles without pready before abort; 0 disables the
  // timeout. Must not exceed 2**timeout_width - 1.
  parameter int TIMEOUT       = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  // host request side
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [addrWidth-1:0] req_addr,
  input  logic [dataWidth-1:0] req_wdata,
  // host response side
  output logic                 rsp_valid,
  output logic [dataWidth-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic [7:0]           err_count,
  output logic                 busy,
  // APB master side
  output logic [addrWidth-1:0] paddr,
  output logic                 pwrite,
  output logic                 psel,
  output logic                 penable,
  output logic [dataWidth-1:0] pwdata,
  input  logic [dataWidth-1:0] prdata,
  input  logic                 pready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam bit                     TIMEOUT_EN  = (TIMEOUT != 0);
  localparam logic [timeout_width:0] TIMEOUT_CMP = (timeout_width + 1)'(TIMEOUT);

  state_t                 state_q, state_d;
  logic [timeout_width-1:0] wait_q, wait_d;
  logic [timeout_width:0]   wait_inc;
  logic                   timeout_hit;

  logic [addrWidth-1:0]   paddr_d;
  logic                   pwrite_d;
  logic [dataWidth-1:0]   pwdata_d;
  logic                   rsp_valid_d;
  logic [dataWidth-1:0]   rsp_rdata_d;
  logic                   rsp_err_d;
  logic [7:0]             err_count_d;

  // Wait count including the current non-ready ACCESS cycle, one bit wider so
  // the comparison against TIMEOUT cannot wrap.
  assign wait_inc    = {1'b0, wait_q} + 1'b1;
  assign timeout_hit = TIMEOUT_EN && (wait_inc == TIMEOUT_CMP);

  // Both come straight from the state register.
  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

  // Next-state and next-output logic; every target defaults to hold.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    paddr_d     = paddr;
    pwrite_d    = pwrite;
    pwdata_d    = pwdata;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    err_count_d = err_count;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          paddr_d  = req_addr;
          pwrite_d = req_write;
          pwdata_d = req_wdata;
          wait_d   = '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          // A completion in the same cycle as the timeout still succeeds.
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite ? '0 : prdata;
          rsp_err_d   = 1'b0;
        end else begin
          wait_d = wait_q + 1'b1;
          if (timeout_hit) begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
            if (err_count != 8'hFF) begin
              err_count_d = err_count + 8'd1;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; psel/penable are registered from the next
  // state so they line up with SETUP/ACCESS without combinational paths.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      err_count <= 8'd0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      paddr     <= paddr_d;
      pwrite    <= pwrite_d;
      pwdata    <= pwdata_d;
      psel      <= (state_d != IDLE);
      penable   <= (state_d == ACCESS);
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      err_count <= err_count_d;
    end
  end

endmodule

// File: tb/tb_apb_host_master.sv
// Bench for apb_host_master: a register-file slave with a programmable number
// of wait states per transfer, a request driver that pushes the expected
// response of each accepted request, a response monitor popping the
// scoreboard, and an APB protocol monitor.
module tb_apb_host_master;
  localparam int AW = 9;
  localparam int DW = 91;
  localparam int TW = 8;
  localparam int TO = 16;
  localparam int NEVER = 1000;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [7:0]    err_count;
  logic          busy;
  logic [AW-1:0] paddr;
  logic          pwrite;
  logic          psel;
  logic          penable;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;

  apb_host_master #(
    .addrWidth(AW), .dataWidth(DW), .timeout_width(TW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .err_count(err_count), .busy(busy),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic [7:0]    errcnt;
    int            lat;
    int            acc_cyc;
  } exp_t;

  exp_t          exp_q[$];
  int            rsp_cyc_q[$];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            model_errs = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  // ---------------- register-file slave ----------------
  logic [DW-1:0] slave_mem [0:(1<<AW)-1];
  int            w_cur = 0;
  int            acc_cnt = 0;

  // pready rises after w_cur non-ready ACCESS cycles; outside ACCESS it
  // carries random noise that the master must ignore.
  always @(negedge clk) begin
    if (psel && penable) begin
      if (acc_cnt == w_cur) begin
        pready = 1'b1;
        if (pwrite) slave_mem[paddr] = pwdata;
        else        prdata = slave_mem[paddr];
      end else begin
        pready = 1'b0;
        prdata = rnd_data();
      end
      acc_cnt++;
    end else begin
      acc_cnt = 0;
      pready  = 1'($urandom_range(0, 1));
      prdata  = rnd_data();
    end
  end

  // ---------------- request driver ----------------
  logic [AW-1:0] cur_addr;
  logic          cur_write;
  logic [DW-1:0] cur_wdata;

  // Presents one request; expected response comes from the reference model
  // (register contents + timeout rule). kill=1 means the request will be cut
  // by reset, so nothing is expected.
  task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input int w, input bit hold, input bit kill);
    logic rdy;
    bit   ok;
    exp_t e;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      rdy = req_ready;
      @(posedge clk);
      if (rdy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      check("accept_timeout", 128'(1), 128'(0));
      req_valid = 1'b0;
      return;
    end
    #1;
    w_cur     = w;
    cur_addr  = addr;
    cur_write = wr;
    cur_wdata = wdata;
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    if (!kill) begin
      e.acc_cyc = cyc;
      if (w >= TO) begin
        e.err   = 1'b1;
        e.rdata = '0;
        e.lat   = TO + 1;
        if (model_errs < 255) model_errs++;
      end else begin
        e.err = 1'b0;
        e.lat = w + 2;
        if (wr) begin
          ref_mem[addr] = wdata;
          e.rdata = '0;
        end else begin
          e.rdata = ref_mem[addr];
        end
      end
      e.errcnt = 8'(model_errs);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle(input int bound);
    bit done;
    done = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin done = 1'b1; break; end
    end
    if (!done) check("drain_timeout", 128'(exp_q.size()), 128'(0));
  endtask

  // ---------------- response monitor ----------------
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      rsp_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 128'(1), 128'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_rdata", 128'(rsp_rdata), 128'(e.rdata));
        check("rsp_err", 128'(rsp_err), 128'(e.err));
        check("err_count", 128'(err_count), 128'(e.errcnt));
        check("rsp_latency", 128'(cyc - e.acc_cyc), 128'(e.lat));
      end
    end
  end

  // ---------------- APB protocol monitor ----------------
  logic prev_psel = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_psel = 1'b0;
    end else begin
      check("busy_vs_psel", 128'(busy), 128'(psel));
      if (penable) check("penable_without_psel", 128'(psel), 128'(1));
      if (psel) begin
        if (!penable) check("idle_gap_before_setup", 128'(prev_psel), 128'(0));
        check("paddr", 128'(paddr), 128'(cur_addr));
        check("pwrite", 128'(pwrite), 128'(cur_write));
        check("pwdata", 128'(pwdata), 128'(cur_wdata));
      end
      prev_psel = psel;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    for (int i = 0; i < (1 << AW); i++) begin
      ref_mem[i]   = '0;
      slave_mem[i] = '0;
    end
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    pready = 1'b0; prdata = '0;
    cur_addr = '0; cur_write = 1'b0; cur_wdata = '0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_psel", 128'(psel), 128'(0));
    check("rst_penable", 128'(penable), 128'(0));
    check("rst_paddr", 128'(paddr), 128'(0));
    check("rst_pwrite", 128'(pwrite), 128'(0));
    check("rst_pwdata", 128'(pwdata), 128'(0));
    check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    check("rst_rsp_rdata", 128'(rsp_rdata), 128'(0));
    check("rst_rsp_err", 128'(rsp_err), 128'(0));
    check("rst_err_count", 128'(err_count), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    rst = 1'b0;
    #1;
    check("rst_req_ready", 128'(req_ready), 128'(1));
    @(negedge clk);

    // write centroid 1, read it back; write/read addr 12
    issue(1'b1, 9'd2, 91'h1234, 1, 1'b0, 1'b0);
    wait_idle(50);
    issue(1'b0, 9'd2, '0, 1, 1'b0, 1'b0);
    wait_idle(50);
    issue(1'b1, 9'd12, 91'h1A5, 0, 1'b0, 1'b0);
    wait_idle(50);
    issue(1'b0, 9'd12, '0, 2, 1'b0, 1'b0);
    wait_idle(50);

    // timeout: pready never rises, then a normal transfer
    issue(1'b0, 9'd3, '0, NEVER, 1'b0, 1'b0);
    wait_idle(100);
    issue(1'b0, 9'd2, '0, 1, 1'b0, 1'b0);
    wait_idle(50);

    // coincidence: pready in the last ACCESS cycle before the timeout fires
    issue(1'b1, 9'd5, rnd_data(), TO - 1, 1'b0, 1'b0);
    wait_idle(100);
    // one past the boundary aborts; the write must not land
    issue(1'b1, 9'd5, rnd_data(), TO, 1'b0, 1'b0);
    wait_idle(100);
    issue(1'b0, 9'd5, '0, 0, 1'b0, 1'b0);
    wait_idle(50);

    // back-to-back writes with req_valid held
    rsp_cyc_q.delete();
    issue(1'b1, 9'd2, rnd_data(), 1, 1'b1, 1'b0);
    issue(1'b1, 9'd3, rnd_data(), 1, 1'b1, 1'b0);
    issue(1'b1, 9'd4, rnd_data(), 1, 1'b0, 1'b0);
    wait_idle(50);
    check("b2b_rsp_count", 128'(rsp_cyc_q.size()), 128'(3));
    if (rsp_cyc_q.size() == 3) begin
      check("b2b_gap_1", 128'(rsp_cyc_q[1] - rsp_cyc_q[0]), 128'(4));
      check("b2b_gap_2", 128'(rsp_cyc_q[2] - rsp_cyc_q[1]), 128'(4));
    end

    // reset in the middle of ACCESS kills the transfer without a response
    issue(1'b1, 9'd7, rnd_data(), NEVER, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("pre_kill_penable", 128'(penable), 128'(1));
    #2 rst = 1'b1;
    #1;
    check("kill_psel", 128'(psel), 128'(0));
    check("kill_penable", 128'(penable), 128'(0));
    check("kill_busy", 128'(busy), 128'(0));
    check("kill_err_count", 128'(err_count), 128'(0));
    model_errs = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    issue(1'b0, 9'd1, '0, 1, 1'b0, 1'b0);
    wait_idle(50);

    // randomized traffic with mixed wait states, aborts and boundaries
    n = 40;
    for (int i = 0; i < n; i++) begin
      int sel;
      int w;
      sel = $urandom_range(0, 9);
      if (sel == 0)      w = TO;
      else if (sel == 1) w = TO - 1;
      else if (sel == 2) w = TO + 3;
      else               w = $urandom_range(0, 4);
      issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), rnd_data(), w,
            (i != n - 1) && ($urandom_range(0, 1) == 1), 1'b0);
    end
    wait_idle(600);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
